// File: rtl/ad9866_spi_responder.sv
// ---------------------------------------------------------------------------
// ad9866_spi_responder
//
// SPI target modelled on the AD9866 control port. All logic runs on clk;
// the SPI pins are asynchronous and are brought into the clk domain through
// SYNC_STAGES-deep synchronizers before any edge detection.
//
// Frame: 16 bits, MSB first, sampled on sclk rising edges.
//   bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data.
// Writes commit on the sen_n rising edge that closes a well-formed frame.
// A read shifts the addressed register out on sdo, changing on sclk falling
// edges; unimplemented addresses read as zero.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   sclk, sen_n    SPI clock and active-low enable (asynchronous)
//   sdio           SPI serial data in (asynchronous)
//   sdo, sdo_oe    serial read data and its drive enable
//   wr_stb         one-clk pulse on a committed write
//   wr_addr/_data  address/data of the last committed write
//   frame_err      one-clk pulse on an aborted or overlong frame
//   lcl_addr       local read-back address
//   lcl_data       register contents at lcl_addr (0 when out of range)
// ---------------------------------------------------------------------------
module ad9866_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NREG        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sen_n,
    input  logic       sdio,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    input  logic [6:0] lcl_addr,
    output logic [7:0] lcl_data
);

    localparam int         IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] NREG_W = 8'(NREG);

    typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA, ST_TAIL} state_e;

    // ---------------- synchronizers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, sdio_sync_q;
    logic                   sclk_prev_q, sen_prev_q;
    logic                   sclk_s, sen_s, sdio_s;
    logic                   sclk_rise, sclk_fall, sen_fall, sen_rise;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sen_s  = sen_sync_q[SYNC_STAGES-1];
    assign sdio_s = sdio_sync_q[SYNC_STAGES-1];

    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign sen_fall  = ~sen_s  &  sen_prev_q;
    assign sen_rise  =  sen_s  & ~sen_prev_q;

    // Reset values match the idle bus levels so releasing rst never
    // manufactures an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sen_sync_q  <= '1;
            sdio_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            sen_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], sen_n};
            sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], sdio};
            sclk_prev_q <= sclk_s;
            sen_prev_q  <= sen_s;
        end
    end

    // ---------------- frame state ----------------
    state_e     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic       ovf_q, ovf_d;
    logic [7:0] rd_shift_q, rd_shift_d;
    logic       sdo_q, sdo_d;
    logic       sdo_oe_q, sdo_oe_d;
    logic       wr_stb_q, wr_stb_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_err_q, frame_err_d;
    logic       reg_we;

    logic [7:0] regs_q [NREG];

    // Address as it will stand once the 8th instruction bit is shifted in;
    // lets the read value be fetched in the same clk that enters DATA.
    logic [6:0] addr_in;
    logic [7:0] rd_val;

    assign addr_in  = {shift_q[5:0], sdio_s};
    assign rd_val   = ({1'b0, addr_in} < NREG_W) ? regs_q[addr_in[IDX_W-1:0]] : 8'h00;
    assign lcl_data = ({1'b0, lcl_addr} < NREG_W) ? regs_q[lcl_addr[IDX_W-1:0]] : 8'h00;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q;
        rd_shift_d  = rd_shift_q;
        sdo_d       = sdo_q;
        sdo_oe_d    = sdo_oe_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        reg_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sen_fall) begin
                    state_d   = ST_INSTR;
                    bit_cnt_d = 5'd0;
                    shift_d   = 8'h00;
                    ovf_d     = 1'b0;
                    // An sclk edge coincident with the enable is bit 15.
                    if (sclk_rise) begin
                        shift_d   = {7'd0, sdio_s};
                        bit_cnt_d = 5'd1;
                    end
                end
            end

            ST_INSTR: begin
                if (sen_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], sdio_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d = ST_DATA;
                        rw_d    = shift_q[6];
                        addr_d  = addr_in;
                        if (shift_q[6]) begin
                            rd_shift_d = rd_val;
                            sdo_d      = rd_val[7];
                            sdo_oe_d   = 1'b1;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (sen_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    sdo_d       = 1'b0;
                    sdo_oe_d    = 1'b0;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], sdio_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d  = ST_TAIL;
                        sdo_d    = 1'b0;
                        sdo_oe_d = 1'b0;
                    end
                end else if (sclk_fall && rw_q && bit_cnt_q >= 5'd9) begin
                    // The fall right after bit 8 is skipped: the MSB was
                    // loaded on entry and must survive until the 9th rise.
                    rd_shift_d = {rd_shift_q[6:0], 1'b0};
                    sdo_d      = rd_shift_q[6];
                end
            end

            ST_TAIL: begin
                if (sclk_rise) begin
                    ovf_d = 1'b1;
                end
                if (sen_rise) begin
                    state_d = ST_IDLE;
                    if (ovf_q || sclk_rise) begin
                        frame_err_d = 1'b1;
                    end else if (!rw_q) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = shift_q;
                        reg_we    = ({1'b0, addr_q} < NREG_W);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            rd_shift_q  <= '0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            rd_shift_q  <= rd_shift_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: the register file is reset because software expects every
    // register to read 0 after rst; this keeps it out of RAM macros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs_q[addr_q[IDX_W-1:0]] <= shift_q;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule
